clock_time_controller: RTL and testbench

- Sequencing controller for the clock's time counters: seconds (6-bit, 0–59), minutes (6-bit, 0–59) and hours (5-bit, 0–23).
- Divides the system clock into a 1 Hz tick and issues single-cycle increment/clear strobes to the counters.
- Carries seconds into minutes and minutes into hours.
- Runs a button-driven time-set state machine with a blink indication.
- The counters do their own wrap-around; this block only decides when they step.

---
 rtl/clock_time_controller.sv | 199 +++++++++++++++++++
 tb/tb_clock_time_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/clock_time_controller.sv
// Time-of-day sequencing controller: 1 Hz prescaler, counter strobes with carry, button-driven set FSM, blink.
// Optional auto-repeat on held increment button in SET_HOUR/SET_MIN when CLOCK_AUTOREPEAT_EN is defined.
module clock_time_controller #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic       tick_1hz,
    output logic       sec_inc,
    output logic       sec_clr,
    output logic       min_inc,
    output logic       hour_inc,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    localparam int PW = $clog2(CLK_HZ + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam int BLINK_HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_HALF = (BLINK_HALF_RAW < 1) ? 1 : BLINK_HALF_RAW;
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    mode_t          mode_q, mode_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
    logic           blink_q, blink_d;
    logic           mode_prev_q, mode_prev_d;
    logic           inc_prev_q, inc_prev_d;
    logic           tick_q, tick_d;
    logic           sec_inc_q, sec_inc_d;
    logic           sec_clr_q, sec_clr_d;
    logic           min_inc_q, min_inc_d;
    logic           hour_inc_q, hour_inc_d;
    logic           mode_edge, inc_edge, presc_at_max;

`ifdef CLOCK_AUTOREPEAT_EN
    localparam int RPT_RAW = CLK_HZ / 8;
    localparam int RPT = (RPT_RAW < 1) ? 1 : RPT_RAW;
    localparam int RW = $clog2(RPT + 1);
    localparam logic [RW-1:0] RATE_MAX = RW'(RPT - 1);

    logic           armed_q, armed_d;
    logic           rpt_q, rpt_d;
    logic [PW-1:0]  hold_q, hold_d;
    logic [RW-1:0]  rate_q, rate_d;
    logic           rpt_fire;
`endif

    always_comb begin
        mode_edge    = mode_btn & ~mode_prev_q;
        // A mode change swallows an inc edge arriving in the same cycle.
        inc_edge     = inc_btn & ~inc_prev_q & ~mode_edge;
        presc_at_max = (presc_q == PRESC_MAX);
        mode_prev_d  = mode_btn;
        inc_prev_d   = inc_btn;
        mode_d       = mode_q;
        presc_d      = '0;
        blink_d      = blink_q;
        blink_cnt_d  = blink_cnt_q;
        tick_d       = 1'b0;
        sec_inc_d    = 1'b0;
        sec_clr_d    = 1'b0;
        min_inc_d    = 1'b0;
        hour_inc_d   = 1'b0;

        if (mode_edge) begin
            mode_d = mode_t'(mode_q + 2'd1);
        end

        case (mode_q)
            MODE_RUN: begin
                if (!mode_edge) begin
                    presc_d    = presc_at_max ? '0 : presc_q + PW'(1);
                    tick_d     = presc_at_max;
                    sec_inc_d  = presc_at_max;
                    min_inc_d  = presc_at_max && (sec == 6'd59);
                    hour_inc_d = presc_at_max && (sec == 6'd59) && (min == 6'd59);
                end
            end
            MODE_SET_HOUR: hour_inc_d = inc_edge;
            MODE_SET_MIN:  min_inc_d  = inc_edge;
            default:       sec_clr_d  = inc_edge;
        endcase

`ifdef CLOCK_AUTOREPEAT_EN
        armed_d  = 1'b0;
        rpt_d    = 1'b0;
        hold_d   = '0;
        rate_d   = '0;
        rpt_fire = 1'b0;
        if ((mode_q == MODE_SET_HOUR || mode_q == MODE_SET_MIN) && !mode_edge) begin
            if (inc_edge) begin
                armed_d = 1'b1;
            end else if (armed_q && inc_btn) begin
                armed_d = 1'b1;
                rpt_d   = rpt_q;
                hold_d  = hold_q;
                rate_d  = rate_q;
                // Hold phase waits CLK_HZ cycles after the edge, then repeat phase fires every RPT cycles.
                if (!rpt_q) begin
                    if (hold_q == PRESC_MAX) begin
                        rpt_d    = 1'b1;
                        rpt_fire = 1'b1;
                    end else begin
                        hold_d = hold_q + PW'(1);
                    end
                end else if (rate_q == RATE_MAX) begin
                    rate_d   = '0;
                    rpt_fire = 1'b1;
                end else begin
                    rate_d = rate_q + RW'(1);
                end
            end
        end
        if (rpt_fire) begin
            if (mode_q == MODE_SET_HOUR) begin
                hour_inc_d = 1'b1;
            end else begin
                min_inc_d = 1'b1;
            end
        end
`endif

        if (mode_d == MODE_RUN) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (mode_edge) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= MODE_RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            mode_prev_q <= mode_btn;
            inc_prev_q  <= inc_btn;
            tick_q      <= 1'b0;
            sec_inc_q   <= 1'b0;
            sec_clr_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            hour_inc_q  <= 1'b0;
`ifdef CLOCK_AUTOREPEAT_EN
            armed_q     <= 1'b0;
            rpt_q       <= 1'b0;
            hold_q      <= '0;
            rate_q      <= '0;
`endif
        end else begin
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            mode_prev_q <= mode_prev_d;
            inc_prev_q  <= inc_prev_d;
            tick_q      <= tick_d;
            sec_inc_q   <= sec_inc_d;
            sec_clr_q   <= sec_clr_d;
            min_inc_q   <= min_inc_d;
            hour_inc_q  <= hour_inc_d;
`ifdef CLOCK_AUTOREPEAT_EN
            armed_q     <= armed_d;
            rpt_q       <= rpt_d;
            hold_q      <= hold_d;
            rate_q      <= rate_d;
`endif
        end
    end

    assign tick_1hz = tick_q;
    assign sec_inc  = sec_inc_q;
    assign sec_clr  = sec_clr_q;
    assign min_inc  = min_inc_q;
    assign hour_inc = hour_inc_q;
    assign mode     = mode_q;
    assign blink    = blink_q;

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed bench for clock_time_controller (CLK_HZ=10, BLINK_HZ=1): vector table plus hand sequences.
module tb_clock_time_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] sec = 6'd10;
    logic [5:0] min = 6'd5;
    logic       tick_1hz, sec_inc, sec_clr, min_inc, hour_inc, blink;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_err = 0;

    clock_time_controller #(.CLK_HZ(10), .BLINK_HZ(1)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec(sec), .min(min), .tick_1hz(tick_1hz), .sec_inc(sec_inc),
        .sec_clr(sec_clr), .min_inc(min_inc), .hour_inc(hour_inc),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       rst, mb, ib;
        logic [5:0] s, m;
        logic       tick, si, sc, mi, hi;
        logic [1:0] md;
        logic       bl, bl_chk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst, input logic mb, input logic ib,
                       input logic [5:0] s, input logic [5:0] m,
                       input logic tick, input logic si, input logic sc, input logic mi,
                       input logic hi, input logic [1:0] md, input logic bl, input logic bl_chk);
        vec_t v;
        v.n = n; v.rst = rst; v.mb = mb; v.ib = ib; v.s = s; v.m = m;
        v.tick = tick; v.si = si; v.sc = sc; v.mi = mi; v.hi = hi;
        v.md = md; v.bl = bl; v.bl_chk = bl_chk;
        vecs.push_back(v);
    endtask

    // Inputs are driven and outputs sampled 1 time unit after a rising edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    int cnt, second, first, ticks;

    initial begin
        //   n  rst mb ib  sec  min  tick si sc mi hi md bl chk
        add(2,  1, 0, 0, 10,  5,  0, 0, 0, 0, 0, 0, 0, 1);  // 0 reset
        add(9,  0, 0, 0, 10,  5,  0, 0, 0, 0, 0, 0, 0, 1);  // 1 prescaler at 9
        add(1,  0, 0, 0, 10,  5,  1, 1, 0, 0, 0, 0, 0, 1);  // 2 first tick
        add(1,  0, 0, 0, 10,  5,  0, 0, 0, 0, 0, 0, 0, 1);
        add(8,  0, 0, 0, 10,  5,  0, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 0, 10,  5,  1, 1, 0, 0, 0, 0, 0, 1);  // 5 second tick, 10 later
        add(9,  0, 0, 0, 59, 59,  0, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 0, 59, 59,  1, 1, 0, 1, 1, 0, 0, 1);  // 7 full carry
        add(9,  0, 0, 0, 59, 30,  0, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 0, 59, 30,  1, 1, 0, 1, 0, 0, 0, 1);  // 9 carry into minutes only
        add(1,  0, 1, 0, 59, 30,  0, 0, 0, 0, 0, 1, 1, 1);  // 10 -> SET_HOUR
        add(1,  0, 0, 0, 59, 30,  0, 0, 0, 0, 0, 1, 1, 1);
        add(3,  0, 0, 0, 59, 30,  0, 0, 0, 0, 0, 1, 1, 1);
        add(1,  0, 0, 0, 59, 30,  0, 0, 0, 0, 0, 1, 0, 1);  // 13 blink toggles after 5
        add(12, 0, 0, 0, 59, 30,  0, 0, 0, 0, 0, 1, 0, 1);
        add(1,  0, 1, 0, 59, 59,  0, 0, 0, 0, 0, 2, 1, 1);  // 15 -> SET_MIN
        add(1,  0, 0, 0, 59, 59,  0, 0, 0, 0, 0, 2, 0, 0);
        add(1,  0, 0, 1, 59, 59,  0, 0, 0, 1, 0, 2, 0, 0);  // 17 press 1
        add(1,  0, 0, 0, 59, 59,  0, 0, 0, 0, 0, 2, 0, 0);
        add(1,  0, 0, 1, 59, 59,  0, 0, 0, 1, 0, 2, 0, 0);  // 19 press 2
        add(1,  0, 0, 1, 59, 59,  0, 0, 0, 0, 0, 2, 0, 0);  // 20 held: no extra strobe
        add(1,  0, 0, 0, 59, 59,  0, 0, 0, 0, 0, 2, 0, 0);
        add(1,  0, 0, 1, 59, 59,  0, 0, 0, 1, 0, 2, 0, 0);  // 22 press 3
        add(1,  0, 0, 0, 59, 59,  0, 0, 0, 0, 0, 2, 0, 0);
        add(1,  0, 0, 1, 59, 59,  0, 0, 0, 1, 0, 2, 0, 0);  // 24 press 4
        add(1,  0, 0, 0, 59, 59,  0, 0, 0, 0, 0, 2, 0, 0);
        add(1,  0, 1, 0, 59, 59,  0, 0, 0, 0, 0, 3, 1, 1);  // 26 -> SET_SEC
        add(1,  0, 0, 0, 59, 59,  0, 0, 0, 0, 0, 3, 0, 0);
        add(1,  0, 0, 1, 59, 59,  0, 0, 1, 0, 0, 3, 0, 0);  // 28 sec_clr
        add(1,  0, 0, 0, 59, 59,  0, 0, 0, 0, 0, 3, 0, 0);
        add(1,  0, 1, 0, 10,  5,  0, 0, 0, 0, 0, 0, 0, 1);  // 30 -> RUN
        add(9,  0, 0, 0, 10,  5,  0, 0, 0, 0, 0, 0, 0, 1);
        add(1,  0, 0, 0, 10,  5,  1, 1, 0, 0, 0, 0, 0, 1);  // 32 tick 10 after RUN

        cyc(1);
        foreach (vecs[i]) begin
            logic [7:0] act, exp;
            reset = vecs[i].rst; mode_btn = vecs[i].mb; inc_btn = vecs[i].ib;
            sec = vecs[i].s; min = vecs[i].m;
            cyc(vecs[i].n);
            act = {tick_1hz, sec_inc, sec_clr, min_inc, hour_inc, mode,
                   vecs[i].bl_chk ? blink : 1'b0};
            exp = {vecs[i].tick, vecs[i].si, vecs[i].sc, vecs[i].mi, vecs[i].hi, vecs[i].md,
                   vecs[i].bl_chk ? vecs[i].bl : 1'b0};
            check($sformatf("vec%0d {tick,si,sc,mi,hi,mode,blink}", i), 32'(act), 32'(exp));
        end

        // Simultaneous mode and inc edges in SET_HOUR: mode wins.
        mode_btn = 1'b1; cyc(1); mode_btn = 1'b0; cyc(1);
        check("enter_set_hour mode", 32'(mode), 32'd1);
        mode_btn = 1'b1; inc_btn = 1'b1; cyc(1);
        check("simul_edge mode", 32'(mode), 32'd2);
        check("simul_edge hour_inc+min_inc", 32'({hour_inc, min_inc}), 32'd0);
        mode_btn = 1'b0; inc_btn = 1'b0; cyc(1);
        check("simul_edge after hour_inc", 32'(hour_inc), 32'd0);

        // Reset pulse in SET_SEC mid-count.
        mode_btn = 1'b1; cyc(1); mode_btn = 1'b0; cyc(1);
        check("enter_set_sec mode", 32'(mode), 32'd3);
        cyc(3);
        reset = 1'b1; cyc(1);
        check("midreset {mode,blink,strobes}",
              32'({mode, blink, tick_1hz, sec_inc, sec_clr, min_inc, hour_inc}), 32'd0);
        reset = 1'b0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (tick_1hz && first == 0) first = k;
        end
        check("midreset first tick cycle", 32'(first), 32'd10);

        // Held inc_btn in SET_HOUR for 30 cycles.
        mode_btn = 1'b1; cyc(1); mode_btn = 1'b0; cyc(1);
        check("enter_set_hour2 mode", 32'(mode), 32'd1);
        cnt = 0; second = 0; ticks = 0;
        inc_btn = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            if (k == 31) inc_btn = 1'b0;
            cyc(1);
            if (tick_1hz) ticks++;
            if (hour_inc) begin
                cnt++;
                if (cnt == 2) second = k;
            end
        end
        check("hold no tick in set", 32'(ticks), 32'd0);
`ifdef CLOCK_AUTOREPEAT_EN
        check("hold hour_inc count", 32'(cnt), 32'd21);
        check("hold first repeat cycle", 32'(second), 32'd11);
`else
        check("hold hour_inc count", 32'(cnt), 32'd1);
        check("hold no repeat", 32'(second), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
